// File: rtl/ps2_key_tracker.sv
`default_nettype none
// =============================================================================
// Module   : ps2_key_tracker
// Brief    : PS/2 frame receiver with E0/F0 decode, held-key map and event FIFO
// Revision : 1.0
// =============================================================================
module ps2_key_tracker #(
   parameter int                    NUM_KEYS    = 4,
   parameter logic [NUM_KEYS*9-1:0] KEY_MAP     = {9'h174, 9'h16B, 9'h172, 9'h175},
   parameter int                    TIMEOUT_CYC = 10000,
   parameter int                    FIFO_DEPTH  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ps2_clk,
   input  logic                ps2_data,
   output logic [NUM_KEYS-1:0] key_down,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [9:0]          evt_data,
   output logic                frame_err,
   output logic [7:0]          err_cnt,
   output logic                overflow
);

   localparam int            c_AW      = $clog2(FIFO_DEPTH);
   localparam int            c_TW      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [c_AW:0] c_PTR_ONE = (c_AW + 1)'(1);
   localparam logic [c_TW-1:0] c_TO_ONE = c_TW'(1);
   localparam logic [c_TW-1:0] c_TO_MAX = c_TW'(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_clk_meta, r_clk_sync, r_clk_prev;
   logic                r_dat_meta, r_dat_sync;
   logic                w_fall;
   logic                w_data;

   logic [2:0]          r_bit_cnt;
   logic [7:0]          r_shift;
   logic                r_par;
   logic [c_TW-1:0]     r_to_cnt;
   logic                r_done;
   logic                r_frame_err;
   logic [7:0]          r_err_cnt;
   logic                w_done;
   logic                w_err;

   logic                r_ext, r_brk;
   logic                w_is_ext, w_is_brk, w_evt;
   logic [9:0]          w_evt_word;
   logic [NUM_KEYS-1:0] w_key_hit;
   logic [NUM_KEYS-1:0] r_key_down;

   logic [9:0]          r_mem [FIFO_DEPTH];
   logic [c_AW:0]       r_wr_ptr, r_rd_ptr;
   logic                r_overflow;
   logic                w_full, w_empty, w_pop, w_push;

   // Synchronisers idle high so reset release never looks like a falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_clk_meta <= 1'b1;
         r_clk_sync <= 1'b1;
         r_clk_prev <= 1'b1;
         r_dat_meta <= 1'b1;
         r_dat_sync <= 1'b1;
      end else begin
         r_clk_meta <= ps2_clk;
         r_clk_sync <= r_clk_meta;
         r_clk_prev <= r_clk_sync;
         r_dat_meta <= ps2_data;
         r_dat_sync <= r_dat_meta;
      end
   end

   assign w_fall = r_clk_prev & ~r_clk_sync;
   assign w_data = r_dat_sync;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      w_err       = 1'b0;
      case (r_state)
         S_IDLE:   if (w_fall && !w_data) w_state_nxt = S_DATA;
         S_DATA:   if (w_fall && r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
         S_PARITY: if (w_fall) w_state_nxt = S_STOP;
         S_STOP: begin
            if (w_fall) begin
               w_state_nxt = S_IDLE;
               if (w_data && (^{r_shift, r_par})) w_done = 1'b1;
               else                                w_err  = 1'b1;
            end
         end
         default:  w_state_nxt = S_IDLE;
      endcase
      // A fall in the same cycle as expiry still counts as a live bus.
      if (r_state != S_IDLE && !w_fall && r_to_cnt == c_TO_MAX) begin
         w_state_nxt = S_IDLE;
         w_err       = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_par       <= 1'b0;
         r_to_cnt    <= '0;
         r_done      <= 1'b0;
         r_frame_err <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         r_done      <= w_done;
         r_frame_err <= w_err;
         if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
         if (r_state == S_IDLE || w_fall) r_to_cnt <= '0;
         else                             r_to_cnt <= r_to_cnt + c_TO_ONE;
         if (r_state != S_DATA) begin
            r_bit_cnt <= '0;
         end else if (w_fall) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_shift   <= {w_data, r_shift[7:1]};
         end
         if (r_state == S_PARITY && w_fall) r_par <= w_data;
      end
   end

   // r_shift stays stable in IDLE, so it still holds the byte one cycle after completion.
   assign w_is_ext   = (r_shift == 8'hE0);
   assign w_is_brk   = (r_shift == 8'hF0);
   assign w_evt      = r_done && !w_is_ext && !w_is_brk;
   assign w_evt_word = {r_ext, r_brk, r_shift};

   always_ff @(posedge clk) begin
      if (rst || w_err) begin
         r_ext <= 1'b0;
         r_brk <= 1'b0;
      end else if (r_done) begin
         if (w_is_ext) begin
            r_ext <= 1'b1;
         end else if (w_is_brk) begin
            r_brk <= 1'b1;
         end else begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
         end
      end
   end

   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      assign w_key_hit[gi] = w_evt && (KEY_MAP[9*gi +: 9] == {r_ext, r_shift});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_key_down <= '0;
      end else begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            if (w_key_hit[k]) r_key_down[k] <= ~r_brk;
         end
      end
   end

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                    (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign w_pop   = !w_empty && evt_ready;
   assign w_push  = w_evt && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= w_evt_word;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         if (w_evt && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   assign key_down  = r_key_down;
   assign evt_valid = !w_empty;
   assign evt_data  = r_mem[r_rd_ptr[c_AW-1:0]];
   assign frame_err = r_frame_err;
   assign err_cnt   = r_err_cnt;
   assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 The block SHALL have one clock and one reset: `clk`, and `rst`, which is synchronous and active-high.
REQ-002 Parameter `NUM_KEYS`, default 4: number of tracked keys.
REQ-003 Parameter `KEY_MAP`, default {9'h174,9'h16B,9'h172,9'h175}: packed NUM_KEYS*9 bits, one {ext,code} per key; key i occupies bits [9i+8:9i] (defaults: 0=up, 1=down, 2=left, 3=right).
REQ-004 Parameter `TIMEOUT_CYC`, default 10000: maximum number of clk cycles allowed between ps2_clk falling edges inside a frame.
REQ-005 Parameter `FIFO_DEPTH`, default 4: event FIFO depth; must be a power of 2 and at least 2.
REQ-006 Port `clk`, input, 1: system clock.
REQ-007 Port `rst`, input, 1: synchronous active-high reset.
REQ-008 Port `ps2_clk`, input, 1: asynchronous PS/2 clock line.
REQ-009 Port `ps2_data`, input, 1: asynchronous PS/2 data line.
REQ-010 Port `key_down`, output, NUM_KEYS: held state of each mapped key (1 = pressed).
REQ-011 Port `evt_valid`, output, 1: FIFO head is valid.
REQ-012 Port `evt_ready`, input, 1: consumer accepts the head event.
REQ-013 Port `evt_data`, output, 10: head event {ext,brk,code[7:0]}; don't-care when evt_valid=0.
REQ-014 Port `frame_err`, output, 1: one-cycle pulse on a parity, stop-bit or timeout error.
REQ-015 Port `err_cnt`, output, 8: error count, saturating at 255.
REQ-016 Port `overflow`, output, 1: sticky flag, set when an event is dropped because the FIFO is full.

Function
REQ-017 ps2_clk and ps2_data SHALL each pass through a 2-flop synchroniser; a falling edge ("fall") is detected when the previous synchronised clk=1 and the current=0, and data is sampled from the synchronised data in that same cycle.
REQ-018 The frame FSM SHALL use the states IDLE, DATA, PARITY and STOP. In IDLE, a fall with data=0 goes to DATA; a fall with data=1 is ignored.
REQ-019 In DATA, each fall SHALL shift in data LSB-first; after the 8th bit the FSM goes to PARITY.
REQ-020 In PARITY, a fall SHALL capture the parity bit and go to STOP.
REQ-021 In STOP, on a fall the FSM SHALL complete the byte if data=1 and the 9 bits (8 data + parity) contain an odd number of ones; otherwise it raises frame_err. In both cases it returns to IDLE.
REQ-022 In any state other than IDLE, the cycle counter SHALL reset on every fall. When the counter reaches TIMEOUT_CYC, the FSM SHALL go to IDLE, pulse frame_err and discard the partial byte.
REQ-023 On a completed byte: 8'hE0 SHALL set ext; 8'hF0 SHALL set brk; any other value SHALL form the event {ext,brk,byte} and clear both ext and brk.
REQ-024 Every frame_err SHALL also clear ext and brk.
REQ-025 An event SHALL be registered on the edge after byte completion (edge N+1 when byte completion is at edge N). The event is pushed to the FIFO, and key_down updates on that same edge N+1.
REQ-026 For each i with KEY_MAP[i]=={ext,code}: brk=0 sets key_down[i] and brk=1 clears it. Unmapped events are pushed to the FIFO only. Duplicate KEY_MAP entries update all matching bits.
REQ-027 Every event SHALL be pushed to the FIFO. A pop occurs when evt_valid&&evt_ready. evt_valid=1 whenever the FIFO is non-empty. Events are delivered in FIFO order.
REQ-028 On a push when the FIFO is full with no pop in that cycle, the event SHALL be dropped and overflow set; key_down still updates.
REQ-029 On a push when the FIFO is full with a pop in the same cycle, the push SHALL be accepted and overflow left unchanged.
REQ-030 A pop from an empty FIFO SHALL have no effect.
REQ-031 err_cnt SHALL increment on each frame_err pulse and hold at 255.

Reset
REQ-032 On reset, key_down, evt_valid, frame_err, err_cnt and overflow SHALL all be 0.
REQ-033 On reset, the FSM SHALL return to IDLE; the bit counter, timeout counter, ext and brk SHALL clear; and the FIFO pointers SHALL empty the FIFO.
REQ-034 Synchroniser flops SHALL reset to 1 (idle bus), so that no false fall is detected after reset.
REQ-035 A reset asserted mid-frame SHALL discard the frame. The first complete frame after reset release SHALL decode normally.

Verification
REQ-036 Send E0,75 -> evt_data=10'h275, key_down=4'b0001. Then send E0,F0,75 -> evt_data=10'h375, key_down=4'b0000.
REQ-037 Send byte 1C with even parity -> one frame_err pulse, err_cnt=1, no event, key_down unchanged.
REQ-038 Send start bit plus 4 data bits, then hold ps2_clk high for TIMEOUT_CYC cycles -> frame_err, err_cnt=1. A following valid frame 1C -> evt_data=10'h01C.
REQ-039 With evt_ready=0, send make codes 1C,32,21,23,24 -> 4 events queued (1C first), overflow=1, 24 lost. Then assert evt_ready -> events drain in order and evt_valid falls after the 4th pop.
REQ-040 With the FIFO full, a push and a pop in the same cycle -> occupancy stays 4 and overflow stays 0.
REQ-041 Assert rst after 6 bits of frame 75 -> all outputs 0. The next frame E0,75 -> key_down[0]=1.
